// File: rtl/ccc_pkg.sv
// ccc_pkg: shared definitions for the 4x4 colour-cell-compression encoder.
//   - Block and field geometry: pixel width, encoded-block width, and the
//     offsets of the bitmap, color0 and color1 fields.
//   - The encoder FSM state enum.
//   - Luma weights and the luma helper.
// Build option CCC_ENC_LUMA_WEIGHTED_EN selects the luma formula:
//   defined   : Y = (77R + 150G + 29B) >> 8, computed in 16 bits
//   undefined : Y = (R + 2G + B) >> 2, computed in 10 bits
package ccc_pkg;

    localparam int BITS_PER_PIXEL = 24;
    localparam int BITS_PER_BLOCK = 64;
    localparam int PIXELS         = 16;

    localparam int BITMAP_LSB = 0;
    localparam int BITMAP_W   = 16;
    localparam int COLOR0_LSB = 16;
    localparam int COLOR1_LSB = 40;

    localparam logic [15:0] LUMA_W_R = 16'd77;
    localparam logic [15:0] LUMA_W_G = 16'd150;
    localparam logic [15:0] LUMA_W_B = 16'd29;

    // 12 divider steps plus one write-back cycle (counter runs 12..0).
    localparam logic [3:0] DIV_CYCLES = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LUMA,
        ST_CLASS,
        ST_DIV
    } ccc_state_e;

    function automatic logic [7:0] luma(input logic [23:0] px);
`ifdef CCC_ENC_LUMA_WEIGHTED_EN
        return 8'((LUMA_W_R * {8'd0, px[23:16]}
                 + LUMA_W_G * {8'd0, px[15:8]}
                 + LUMA_W_B * {8'd0, px[7:0]}) >> 8);
`else
        return 8'(({2'd0, px[23:16]} + {1'd0, px[15:8], 1'b0} + {2'd0, px[7:0]}) >> 2);
`endif
    endfunction

    // A group average never exceeds 255; clamp guards the divide-by-zero case.
    function automatic logic [7:0] sat8(input logic [11:0] v);
        return (v > 12'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/ccc_div_u12.sv
// ccc_div_u12: iterative restoring divider, 12-bit dividend / 5-bit divisor.
// The first quotient bit is resolved on the start edge, so the quotient is
// complete 12 rising edges after (and including) the start edge.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     load operands and perform the first step
//   dividend_i  12-bit unsigned dividend (sampled on start)
//   divisor_i   5-bit unsigned divisor (sampled on start)
//   quotient_o  12-bit quotient, valid once 12 steps have run
module ccc_div_u12 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [11:0] dividend_i,
    input  logic [4:0]  divisor_i,
    output logic [11:0] quotient_o
);

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    logic [11:0] quo_q;
    logic [4:0]  rem_q;
    logic [4:0]  dvs_q;
    logic [3:0]  cnt_q;

    logic        in_bit;
    logic [4:0]  rem_in;
    logic [4:0]  dvs;
    logic [5:0]  trial;
    logic        q_bit;
    logic [4:0]  rem_d;

    always_comb begin
        in_bit = quo_q[11];
        rem_in = rem_q;
        dvs    = dvs_q;
        if (start_i) begin
            in_bit = dividend_i[11];
            rem_in = 5'd0;
            dvs    = divisor_i;
        end
        trial = {rem_in, in_bit};
        q_bit = (trial >= {1'b0, dvs});
        rem_d = q_bit ? 5'(trial - {1'b0, dvs}) : trial[4:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            quo_q <= {dividend_i[10:0], q_bit};
            rem_q <= rem_d;
            dvs_q <= divisor_i;
            cnt_q <= 4'd11;
        end else if (cnt_q != 4'd0) begin
            quo_q <= {quo_q[10:0], q_bit};
            rem_q <= rem_d;
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign quotient_o = quo_q;

endmodule

// File: rtl/ccc_encoder_4x4.sv
// ccc_encoder_4x4: encodes a 4x4 RGB888 block into a 64-bit CCC word
// {color1[63:40], color0[39:16], bitmap[15:0]}. Completion lands on the
// 45th rising edge after the start-accepting edge.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset (priority over start)
//   start_i     encode request, sampled only in IDLE
//   rgb_data_i  16 pixels, pixel i at [i*24 +: 24], {R,G,B}
//   ccc_data_o  registered encoded block, updated only at completion
//   done_o      level, high from completion until the next accepted start
//   busy_o      high while an encode is in progress
// Build option CCC_ENC_LUMA_WEIGHTED_EN selects the luma formula (see ccc_pkg).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; ccc_data/done hold
// ST_LUMA  | 16 cycles: Y[i] stored, luma sum accumulated
// ST_CLASS | 16 cycles: bitmap bit, group channel sums and counts
// ST_DIV   | 12 divider steps then one write-back cycle
module ccc_encoder_4x4
    import ccc_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [PIXELS*BITS_PER_PIXEL-1:0] rgb_data_i,
    output logic [BITS_PER_BLOCK-1:0]     ccc_data_o,
    output logic                          done_o,
    output logic                          busy_o
);

    ccc_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [PIXELS*BITS_PER_PIXEL-1:0] blk_q;
    logic [7:0]  y_q [PIXELS];
    logic [11:0] sum_q;
    logic [15:0] bitmap_q;
    logic [11:0] csum_q [2][3];
    logic [4:0]  gcnt_q [2];
    logic [BITS_PER_BLOCK-1:0] ccc_q;
    logic        done_q;

    logic [3:0]  pix_idx;
    logic [23:0] cur_px;
    logic [7:0]  y_cur;
    logic        bright;
    logic        div_start;
    logic [11:0] quo [2][3];
    logic [23:0] color_grp [2];
    logic [BITS_PER_BLOCK-1:0] result;

    // The down-counter walks pixels 0..15 as it counts 15..0.
    assign pix_idx   = 4'd15 - cnt_q;
    assign cur_px    = blk_q[pix_idx*BITS_PER_PIXEL +: BITS_PER_PIXEL];
    assign y_cur     = luma(cur_px);
    assign bright    = (y_q[pix_idx] >= sum_q[11:4]);
    assign div_start = (state_q == ST_DIV) && (cnt_q == DIV_CYCLES);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LUMA;
                    cnt_d   = 4'd15;
                end
            end
            ST_LUMA: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CLASS;
                    cnt_d   = 4'd15;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CLASS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DIV;
                    cnt_d   = DIV_CYCLES;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DIV: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blk_q    <= '0;
            sum_q    <= '0;
            bitmap_q <= '0;
            ccc_q    <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < PIXELS; i++) y_q[i] <= '0;
            for (int g = 0; g < 2; g++) begin
                gcnt_q[g] <= '0;
                for (int k = 0; k < 3; k++) csum_q[g][k] <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        blk_q    <= rgb_data_i;
                        done_q   <= 1'b0;
                        sum_q    <= '0;
                        bitmap_q <= '0;
                        for (int g = 0; g < 2; g++) begin
                            gcnt_q[g] <= '0;
                            for (int k = 0; k < 3; k++) csum_q[g][k] <= '0;
                        end
                    end
                end
                ST_LUMA: begin
                    y_q[pix_idx] <= y_cur;
                    sum_q        <= sum_q + {4'd0, y_cur};
                end
                ST_CLASS: begin
                    bitmap_q[pix_idx] <= bright;
                    gcnt_q[bright]    <= gcnt_q[bright] + 5'd1;
                    for (int k = 0; k < 3; k++)
                        csum_q[bright][k] <= csum_q[bright][k] + {4'd0, cur_px[k*8 +: 8]};
                end
                ST_DIV: begin
                    if (cnt_q == 4'd0) begin
                        ccc_q  <= result;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel k: 0 = B, 1 = G, 2 = R; group 0 = dark, group 1 = bright.
    for (genvar g = 0; g < 2; g++) begin : g_grp
        for (genvar k = 0; k < 3; k++) begin : g_ch
            ccc_div_u12 u_div (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .start_i    (div_start),
                .dividend_i (csum_q[g][k]),
                .divisor_i  (gcnt_q[g]),
                .quotient_o (quo[g][k])
            );
        end
        assign color_grp[g] = {sat8(quo[g][2]), sat8(quo[g][1]), sat8(quo[g][0])};
    end

    // An empty group borrows the other group's colour.
    always_comb begin
        result = '0;
        result[BITMAP_LSB +: BITMAP_W] = bitmap_q;
        result[COLOR0_LSB +: BITS_PER_PIXEL] = (gcnt_q[0] == 5'd0) ? color_grp[1] : color_grp[0];
        result[COLOR1_LSB +: BITS_PER_PIXEL] = (gcnt_q[1] == 5'd0) ? color_grp[0] : color_grp[1];
    end

    assign ccc_data_o = ccc_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: doc/ccc_encoder_4x4.md
CCC_ENCODER_4X4 -- requirements
Module: ccc_encoder_4x4

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to encode the block on rgb_data; sampled only in IDLE.
REQ-005 rgb_data  input  384  4x4 pixels; row r at [r*96 +: 96], column c at [c*24 +: 24] within the row; pixel {R[23:16],G[15:8],B[7:0]}; pixel index i = r*4+c.
REQ-006 ccc_data  output  64  encoded block: [15:0] bitmap (bit i = pixel i), [39:16] color0 (dark), [63:40] color1 (bright).
REQ-007 done  output  1  level; high from completion until the next accepted start.
REQ-008 busy  output  1  high while an encode is in progress.

Function
REQ-009 SHALL implement FSM IDLE -> LUMA -> CLASS -> DIV -> IDLE.
REQ-010 SHALL leave IDLE when start=1: latch rgb_data, clear done, set busy.
REQ-011 SHALL ignore start and rgb_data changes while busy.
REQ-012 LUMA: SHALL process one pixel per cycle for 16 cycles, storing Y[i] (8 bit) and accumulating a 12-bit luminance sum.
REQ-013 Y[i] SHALL be (77R + 150G + 29B) >> 8, computed in 16 bits and truncated.
REQ-014 mean SHALL be sum >> 4.
REQ-015 CLASS: SHALL process one pixel per cycle for 16 cycles.
- bitmap bit i = (Y[i] >= mean).
- Each channel of the pixel SHALL be added to the 12-bit per-channel sums of its group.
- The 5-bit count of its group SHALL be incremented.
REQ-016 DIV: SHALL take 12 cycles; each group color channel = floor(channel sum / group count).
REQ-017 A group with count 0 SHALL take the other group's color (no divide by zero is exposed).
REQ-018 ccc_data SHALL be registered and SHALL update only at completion; it holds its value otherwise.
REQ-019 done SHALL rise, busy SHALL fall and ccc_data SHALL update on the 45th rising edge after the edge that accepted start.
REQ-020 start=1 in the cycle done rises SHALL NOT be accepted; start is accepted from the following cycle.
REQ-021 Back-to-back starts SHALL each complete in exactly 45 cycles.

Reset
REQ-022 rst=1 SHALL force IDLE with ccc_data=0, done=0, busy=0, and clear all accumulators and counters.
REQ-023 rst asserted mid-encode SHALL abort the encode with no partial ccc_data update.
REQ-024 rst SHALL take priority over start in the same cycle.

Configuration
REQ-025 SHALL use macro CCC_ENC_LUMA_WEIGHTED_EN.
- Defined: Y per REQ-013.
- Undefined: Y = (R + 2G + B) >> 2, computed in 10 bits.
- Latency and format SHALL be identical in both builds.

Structure
REQ-026 Shared package ccc_pkg SHALL hold:
- BITS_PER_PIXEL=24 and BITS_PER_BLOCK=64.
- Field offsets for the bitmap, color0 and color1.
- The FSM state enum.
- The luma weight constants.
REQ-027 SHALL instantiate six copies of sub-module ccc_div_u12: an iterative restoring divider, 12-bit dividend, 5-bit divisor, 12-cycle fixed latency.

Verification
REQ-028 All 16 pixels 0x804020 -> ccc_data = {24'h804020, 24'h804020, 16'hFFFF}, done at cycle 45, busy low at cycle 45.
REQ-029 Columns 0-1 = 0x000000, columns 2-3 = 0xFFFFFF -> bitmap 0xCCCC, color0 0x000000, color1 0xFFFFFF.
REQ-030 Pixel 0 = 0xFF0000, rest 0x000000 -> bitmap 0x0001, color1 0xFF0000, color0 0x000000, in both macro builds.
REQ-031 Flooring case: pixels 0-7 = 0x101010, 8-14 = 0xF0F0F0, 15 = 0xF1F1F1 -> mean 128, bitmap 0xFF00, color0 0x101010, color1 0xF0F0F0 (floor of 1921/8).
REQ-032 start pulse with block A, second start with block B at cycle 10 -> output encodes A only at cycle 45.
- Then rst at cycle 20 of a new encode -> done=0, ccc_data=0.
- A following start completes in 45 cycles.
